// File: rtl/somador_pkg.sv
// Shared constants for the somador_subtrator adder/subtractor.
package somador_pkg;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/somador_subtrator_bit.sv
// One-bit full adder / full subtractor cell; Te/Ts chain carry (add) or borrow (sub).
module somador_subtrator_bit
    import somador_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic Te,
    input  logic M,
    output logic S,
    output logic Ts
);
    logic x;

    assign x = A ^ B;
    assign S = x ^ Te;
    // Borrow out when the minuend bit cannot cover the subtrahend plus incoming borrow.
    assign Ts = (M == MODE_SUB) ? ((~A & B) | (Te & ~x))
                                : ((A & B) | (Te & x));
endmodule

// File: rtl/somador_subtrator.sv
// WIDTH-bit ripple adder/subtractor with a single registered output stage.
module somador_subtrator
    import somador_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Te,
    input  logic             M,
    output logic [WIDTH-1:0] S,
    output logic             Ts
);
    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             ts_q;

    assign chain[0] = Te;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        somador_subtrator_bit u_bit (
            .A  (A[i]),
            .B  (B[i]),
            .Te (chain[i]),
            .M  (M),
            .S  (s_d[i]),
            .Ts (chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            ts_q <= 1'b0;
        end else begin
            s_q  <= s_d;
            ts_q <= chain[WIDTH];
        end
    end

    assign S  = s_q;
    assign Ts = ts_q;
endmodule

// File: tb/tb_somador_subtrator.sv
// Scoreboard bench driving a 1-bit and a 4-bit instance side by side.
module tb_somador_subtrator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, te1 = 1'b0, m1 = 1'b0;
    logic       s1, ts1;
    logic [3:0] a4 = '0, b4 = '0;
    logic       te4 = 1'b0, m4 = 1'b0;
    logic [3:0] s4;
    logic       ts4;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] s4;
        logic       ts4;
        logic       s1;
        logic       ts1;
        string      tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    somador_subtrator #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Te(te1), .M(m1), .S(s1), .Ts(ts1)
    );

    somador_subtrator #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Te(te4), .M(m4), .S(s4), .Ts(ts4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Unsigned reference: returns {Ts, S} packed as Ts<<w | S.
    function automatic int model(int w, int a, int b, int te, int m);
        int mod, r, s, ts;
        mod = 1 << w;
        if (m == 0) begin
            r  = a + b + te;
            s  = r % mod;
            ts = r / mod;
        end else begin
            r  = a - b - te;
            s  = (r + 2 * mod) % mod;
            ts = (a < b + te) ? 1 : 0;
        end
        return (ts << w) | s;
    endfunction

    task automatic drive(input string tag, input bit r,
                         input int xa1, input int xb1, input int xte1, input int xm1,
                         input int xa4, input int xb4, input int xte4, input int xm4);
        exp_t e;
        int   r1, r4;
        @(negedge clk);
        rst = r;
        a1 = xa1[0]; b1 = xb1[0]; te1 = xte1[0]; m1 = xm1[0];
        a4 = xa4[3:0]; b4 = xb4[3:0]; te4 = xte4[0]; m4 = xm4[0];
        r1 = model(1, xa1, xb1, xte1, xm1);
        r4 = model(4, xa4, xb4, xte4, xm4);
        e.tag = tag;
        e.s1  = r ? 1'b0 : r1[0];
        e.ts1 = r ? 1'b0 : r1[1];
        e.s4  = r ? 4'd0 : r4[3:0];
        e.ts4 = r ? 1'b0 : r4[4];
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, ".s1"},  32'(s1),  32'(e.s1));
            chk({e.tag, ".ts1"}, 32'(ts1), 32'(e.ts1));
            chk({e.tag, ".s4"},  32'(s4),  32'(e.s4));
            chk({e.tag, ".ts4"}, 32'(ts4), 32'(e.ts4));
        end
    end

    // 4-bit directed vectors {M, A, B, Te} run alongside the 1-bit exhaustive sweep.
    int v4 [0:15][4] = '{
        '{0, 9, 8, 1}, '{0, 3, 4, 0}, '{1, 3, 5, 0}, '{1, 7, 7, 0},
        '{1, 0, 0, 1}, '{0, 15, 15, 1}, '{0, 15, 0, 1}, '{1, 0, 15, 1},
        '{1, 15, 0, 0}, '{0, 0, 0, 0}, '{1, 8, 8, 1}, '{0, 8, 8, 0},
        '{1, 4, 3, 1}, '{1, 4, 3, 0}, '{0, 7, 8, 1}, '{1, 1, 2, 0}
    };

    initial begin
        // Reset held with nonzero operands must still yield zero outputs.
        drive("rst0", 1, 1, 1, 1, 0, 1, 1, 1, 0);
        drive("rst1", 1, 1, 1, 1, 0, 1, 1, 1, 0);
        drive("rel",  0, 1, 1, 1, 0, 1, 1, 1, 0);

        for (int i = 0; i < 16; i++) begin
            drive("exh", 0, (i >> 2) & 1, (i >> 1) & 1, i & 1, (i >> 3) & 1,
                  v4[i][1], v4[i][2], v4[i][3], v4[i][0]);
        end

        for (int i = 0; i < 8; i++)
            drive("tog", 0, 1, 0, 0, i & 1, 5, 2, 0, i & 1);

        drive("pre", 0, 1, 0, 1, 1, 9, 8, 1, 0);
        drive("mrst", 1, 1, 1, 0, 0, 12, 3, 0, 1);
        drive("post", 0, 0, 1, 1, 0, 3, 5, 0, 1);

        for (int i = 0; i < 24; i++)
            drive("rnd", 0, $urandom_range(1), $urandom_range(1), $urandom_range(1),
                  $urandom_range(1), $urandom_range(15), $urandom_range(15),
                  $urandom_range(1), $urandom_range(1));

        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/somador_subtrator.md
Name: somador_subtrator

Overview:
- Clocked, WIDTH-bit ripple adder/subtractor built from 1-bit full adder/subtractor cells.
- Mode input M selects addition (M=0) or subtraction (M=1).
- Te is the carry-in (add) or borrow-in (subtract); Ts is the carry-out or borrow-out.
- Used as a basic arithmetic cell in datapaths; WIDTH=1 is the canonical single-bit configuration.

Parameters:
- WIDTH, 1, operand and result width in bits (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- A  input  WIDTH  operand A (minuend when M=1).
- B  input  WIDTH  operand B (subtrahend when M=1).
- Te  input  1  carry-in (M=0) / borrow-in (M=1), applied at bit 0.
- M  input  1  mode: 0 = add, 1 = subtract.
- S  output  WIDTH  registered sum/difference.
- Ts  output  1  registered carry-out (M=0) / borrow-out (M=1) from bit WIDTH-1.

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: on a rising clk edge with rst=1, S=0 and Ts=0. Reset overrides all inputs.
  - A reset asserted mid-stream discards the in-flight result.
  - The first result after rst deasserts reflects inputs sampled on that first non-reset edge.
- Latency: exactly 1 cycle.
  - Inputs are sampled on rising edge N; S and Ts are valid after edge N and hold until the next edge.
  - Throughput: one operation per cycle. No handshake; no state beyond the output registers.
- Per-bit cell i, with c0 = Te and ci the chain input for bit i:
  - s_i = A_i ^ B_i ^ c_i (same for both modes).
  - M=0: c_{i+1} = A_i&B_i | c_i&(A_i^B_i).
  - M=1: c_{i+1} = ~A_i&B_i | c_i&~(A_i^B_i), which is a borrow.
  - Ts = c_WIDTH.
- Arithmetic meaning (unsigned):
  - M=0: {Ts,S} = A + B + Te, exact in WIDTH+1 bits.
  - M=1: S = (A − B − Te) mod 2^WIDTH. Ts=1 exactly when A < B + Te (borrow, not two's-complement carry).
- Boundaries:
  - All-ones addition with Te=1 gives S=all ones, Ts=1.
  - 0 − 0 − 1 gives S=all ones, Ts=1.
  - A=B with Te=0 in subtract mode gives S=0, Ts=0.
- M changing between cycles takes effect on the next sampled edge only. Results are never mixed within one cycle.
- WIDTH=1 truth table (M A B Te → S Ts):
  - Add, M=0: 000→00, 001→10, 010→10, 011→01, 100→10, 101→01, 110→01, 111→11.
  - Subtract, M=1: 000→00, 001→11, 010→11, 011→01, 100→10, 101→00, 110→00, 111→11.
- No X propagation requirements beyond standard; outputs are defined from reset onward.

Decomposition:
- Shared package somador_pkg:
  - localparam MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - No typedefs required.
- Sub-module somador_subtrator_bit: purely combinational 1-bit cell.
  - Ports A, B, Te, M → S, Ts, implementing the per-bit equations above.
  - Instantiated WIDTH times in a generate loop, chained Ts→Te.
  - Top level adds the output register stage with synchronous reset.

Test Plan:
- Reset: drive rst=1 for 2 cycles with A=1, B=1, Te=1, M=0 → S=0, Ts=0. Release rst → next cycle S=1, Ts=1.
- Exhaustive WIDTH=1: all 16 combinations of M, A, B, Te, one per cycle → each output matches the truth table one cycle later (e.g. M=1, A=0, B=1, Te=0 → S=1, Ts=1).
- WIDTH=4 add: M=0, A=9, B=8, Te=1 → S=2, Ts=1. Then A=3, B=4, Te=0 → S=7, Ts=0.
- WIDTH=4 subtract: M=1, A=3, B=5, Te=0 → S=14, Ts=1. Then A=7, B=7, Te=0 → S=0, Ts=0. Then A=0, B=0, Te=1 → S=15, Ts=1.
- Back-to-back mode toggle, WIDTH=4: alternate M=0/1 each cycle with A=5, B=2, Te=0 → S alternates 7, 3, with Ts=0 throughout and no stale values.
- Mid-stream reset: assert rst for one cycle between two valid operations → that cycle's output is S=0, Ts=0. The following operation's result is correct with 1-cycle latency.
